mpi_send_arbiter: RTL and testbench

Round-robin arbiter that shares the single MPI `sender` channel between `NUM_REQ` local requesters. Each requester presents a message and destination rank over a valid/yumi handshake. The arbiter captures one message at a time into an output register and drives the sender-side valid/yumi port. Sends are gated by a credit counter that is decremented per captured message and replenished by `credit_return` pulses from the remote receiver.

---
 rtl/mpi_send_arbiter_if.sv | 32 +++
 rtl/mpi_send_arbiter.sv | 103 ++++++++++
 tb/tb_mpi_send_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mpi_send_arbiter_if.sv
// Requester, sender and credit signals of the MPI send arbiter.
// The arbiter connects through the slave modport; requesters and the sender use master.
interface mpi_send_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int DEST_W  = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*DEST_W-1:0] req_dest;
  logic [NUM_REQ-1:0]        req_yumi;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [DEST_W-1:0]         out_dest;
  logic [SRC_W-1:0]          out_src;
  logic                      out_yumi;
  logic                      credit_return;
  logic [7:0]                credit_count;
  logic                      credit_overflow;

  modport master (
    output req_valid, req_data, req_dest, out_yumi, credit_return,
    input  req_yumi, out_valid, out_data, out_dest, out_src, credit_count, credit_overflow
  );

  modport slave (
    input  req_valid, req_data, req_dest, out_yumi, credit_return,
    output req_yumi, out_valid, out_data, out_dest, out_src, credit_count, credit_overflow
  );
endinterface

// File: rtl/mpi_send_arbiter.sv
// Round-robin, credit-gated arbiter that shares one MPI sender channel
// between NUM_REQ requesters through a single output holding register.
module mpi_send_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int DEST_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mpi_send_arbiter_if.slave   bus
);
  localparam int              SRC_W      = $clog2(NUM_REQ);
  localparam logic [7:0]      CREDIT_MAX = 8'(CREDITS);
  localparam logic [SRC_W:0]  NUM_REQ_W  = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ-1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t              r_state;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [DEST_W-1:0]   r_dest;
  logic [SRC_W-1:0]    r_src;
  logic [SRC_W-1:0]    r_ptr;
  logic [7:0]          r_credit;
  logic                r_overflow;

  logic                w_can_capture;
  logic                w_found;
  logic                w_capture;
  logic [SRC_W-1:0]    w_grant;
  logic [SRC_W:0]      w_sum;
  logic [NUM_REQ-1:0]  w_yumi;

  // Gated by rst_n so no requester is acknowledged while reset is held.
  assign w_can_capture = rst_n && (r_credit != 8'd0) &&
                         ((r_state == ST_IDLE) || bus.out_yumi);

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
      if (!w_found && bus.req_valid[w_sum[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[SRC_W-1:0];
      end
    end
  end

  assign w_capture = w_can_capture && w_found;

  always_comb begin
    w_yumi = '0;
    if (w_capture) w_yumi[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_dest     <= '0;
      r_src      <= '0;
      r_ptr      <= '0;
      r_credit   <= CREDIT_MAX;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_state <= ST_HOLD;
        r_valid <= 1'b1;
        r_data  <= bus.req_data[w_grant*DATA_W +: DATA_W];
        r_dest  <= bus.req_dest[w_grant*DEST_W +: DEST_W];
        r_src   <= w_grant;
        r_ptr   <= (w_grant == LAST_IDX) ? '0 : w_grant + 1'b1;
      end else if ((r_state == ST_HOLD) && bus.out_yumi) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end

      // A return arriving when the counter is already full is saturated and flagged.
      case ({w_capture, bus.credit_return})
        2'b10:   r_credit <= r_credit - 8'd1;
        2'b01: begin
          if (r_credit == CREDIT_MAX) r_overflow <= 1'b1;
          else                        r_credit   <= r_credit + 8'd1;
        end
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign bus.req_yumi        = w_yumi;
  assign bus.out_valid       = r_valid;
  assign bus.out_data        = r_data;
  assign bus.out_dest        = r_dest;
  assign bus.out_src         = r_src;
  assign bus.credit_count    = r_credit;
  assign bus.credit_overflow = r_overflow;
endmodule

// File: tb/tb_mpi_send_arbiter.sv
// Directed bench for mpi_send_arbiter: reset, single send, round-robin,
// credit exhaustion, backpressure, credit overflow and asynchronous reset.
module tb_mpi_send_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  localparam int DEST_W  = 32;
  localparam int CREDITS = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mpi_send_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEST_W(DEST_W)) bus ();

  mpi_send_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEST_W(DEST_W), .CREDITS(CREDITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] dst);
    bus.req_data[i*DATA_W +: DATA_W] = d;
    bus.req_dest[i*DEST_W +: DEST_W] = dst;
  endtask

  task automatic applyReset();
    rst_n             = 1'b0;
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_dest      = '0;
    bus.out_yumi      = 1'b0;
    bus.credit_return = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    bus.req_valid     = 4'hF;
    bus.req_data      = '0;
    bus.req_dest      = '0;
    bus.out_yumi      = 1'b0;
    bus.credit_return = 1'b0;
    tick();
    total++; if (bus.req_yumi !== 4'b0000) begin bad++; $display("[TB] FAIL reset_yumi got=%b want=0000", bus.req_yumi); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 64'd0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_dest !== 32'd0) begin bad++; $display("[TB] FAIL reset_dest got=%h want=0", bus.out_dest); end
    total++; if (bus.out_src !== 2'd0) begin bad++; $display("[TB] FAIL reset_src got=%0d want=0", bus.out_src); end
    total++; if (bus.credit_count !== 8'd4) begin bad++; $display("[TB] FAIL reset_credit got=%0d want=4", bus.credit_count); end
    total++; if (bus.credit_overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", bus.credit_overflow); end
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_send();
    applyReset();
    setReq(2, 64'hDEAD, 32'd0);
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_yumi !== 4'b0100) begin bad++; $display("[TB] FAIL single_yumi got=%b want=0100", bus.req_yumi); end
    tick();
    bus.req_valid = '0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 64'hDEAD) begin bad++; $display("[TB] FAIL single_data got=%h want=dead", bus.out_data); end
    total++; if (bus.out_src !== 2'd2) begin bad++; $display("[TB] FAIL single_src got=%0d want=2", bus.out_src); end
    total++; if (bus.credit_count !== 8'd3) begin bad++; $display("[TB] FAIL single_credit got=%0d want=3", bus.credit_count); end
    bus.out_yumi = 1'b1;
    tick();
    bus.out_yumi = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    applyReset();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 64'hA0 + 64'(i), 32'h10 + 32'(i));
    bus.req_valid = 4'hF;
    bus.out_yumi  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.credit_return = (k > 0);
      #1;
      total++; if (bus.req_yumi !== 4'(1 << (k % 4))) begin bad++; $display("[TB] FAIL rr_yumi[%0d] got=%b want=%b", k, bus.req_yumi, 4'(1 << (k % 4))); end
      tick();
      total++; if (bus.out_src !== 2'(k % 4)) begin bad++; $display("[TB] FAIL rr_src[%0d] got=%0d want=%0d", k, bus.out_src, k % 4); end
      total++; if (bus.out_dest !== 32'h10 + 32'(k % 4)) begin bad++; $display("[TB] FAIL rr_dest[%0d] got=%h want=%h", k, bus.out_dest, 32'h10 + 32'(k % 4)); end
    end
    total++; if (bus.credit_count !== 8'd3) begin bad++; $display("[TB] FAIL rr_credit got=%0d want=3", bus.credit_count); end
    bus.req_valid     = '0;
    bus.credit_return = 1'b0;
    tick();
    bus.out_yumi = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_idle got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_credit_exhaustion();
    int caps;
    applyReset();
    setReq(1, 64'h5151, 32'h77);
    bus.req_valid = 4'b0010;
    bus.out_yumi  = 1'b1;
    caps = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (bus.req_yumi == 4'b0010) caps++;
      tick();
    end
    total++; if (caps !== 4) begin bad++; $display("[TB] FAIL exh_caps got=%0d want=4", caps); end
    total++; if (bus.credit_count !== 8'd0) begin bad++; $display("[TB] FAIL exh_credit got=%0d want=0", bus.credit_count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL exh_valid got=%b want=0", bus.out_valid); end
    bus.credit_return = 1'b1;
    #1;
    total++; if (bus.req_yumi !== 4'b0000) begin bad++; $display("[TB] FAIL exh_ret_yumi got=%b want=0000", bus.req_yumi); end
    tick();
    bus.credit_return = 1'b0;
    #1;
    total++; if (bus.req_yumi !== 4'b0010) begin bad++; $display("[TB] FAIL exh_regrant got=%b want=0010", bus.req_yumi); end
    total++; if (bus.credit_count !== 8'd1) begin bad++; $display("[TB] FAIL exh_credit1 got=%0d want=1", bus.credit_count); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL exh_valid2 got=%b want=1", bus.out_valid); end
    caps = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (bus.req_yumi != 4'b0000) caps++;
      tick();
    end
    total++; if (caps !== 0) begin bad++; $display("[TB] FAIL exh_extra got=%0d want=0", caps); end
    bus.req_valid = '0;
    bus.out_yumi  = 1'b0;
  endtask

  task automatic test_backpressure();
    applyReset();
    setReq(0, 64'h1111, 32'h1);
    setReq(1, 64'h2222, 32'h2);
    setReq(3, 64'h3333, 32'h3);
    bus.req_valid = 4'b0001;
    #1;
    total++; if (bus.req_yumi !== 4'b0001) begin bad++; $display("[TB] FAIL bp_first got=%b want=0001", bus.req_yumi); end
    tick();
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (bus.req_yumi !== 4'b0000) begin bad++; $display("[TB] FAIL bp_yumi[%0d] got=%b want=0000", c, bus.req_yumi); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h1111 || bus.out_src !== 2'd0) begin
        bad++; $display("[TB] FAIL bp_hold[%0d] got=%b/%h/%0d want=1/1111/0", c, bus.out_valid, bus.out_data, bus.out_src);
      end
      tick();
    end
    bus.out_yumi = 1'b1;
    #1;
    total++; if (bus.req_yumi !== 4'b0010) begin bad++; $display("[TB] FAIL bp_next got=%b want=0010", bus.req_yumi); end
    tick();
    total++; if (bus.out_data !== 64'h2222) begin bad++; $display("[TB] FAIL bp_data got=%h want=2222", bus.out_data); end
    bus.req_valid = 4'b1000;
    #1;
    total++; if (bus.req_yumi !== 4'b1000) begin bad++; $display("[TB] FAIL bp_next3 got=%b want=1000", bus.req_yumi); end
    tick();
    bus.req_valid = '0;
    tick();
    bus.out_yumi = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.credit_count !== 8'd1) begin
      bad++; $display("[TB] FAIL bp_end got=%b/%0d want=0/1", bus.out_valid, bus.credit_count);
    end
  endtask

  task automatic test_credit_overflow();
    applyReset();
    setReq(0, 64'h4444, 32'h4);
    bus.req_valid     = 4'b0001;
    bus.credit_return = 1'b1;
    tick();
    bus.req_valid     = '0;
    bus.credit_return = 1'b0;
    total++; if (bus.credit_count !== 8'd4) begin bad++; $display("[TB] FAIL simul_credit got=%0d want=4", bus.credit_count); end
    total++; if (bus.credit_overflow !== 1'b0) begin bad++; $display("[TB] FAIL simul_ovf got=%b want=0", bus.credit_overflow); end
    bus.out_yumi = 1'b1;
    tick();
    bus.out_yumi      = 1'b0;
    bus.credit_return = 1'b1;
    tick();
    bus.credit_return = 1'b0;
    total++; if (bus.credit_count !== 8'd4) begin bad++; $display("[TB] FAIL ovf_credit got=%0d want=4", bus.credit_count); end
    total++; if (bus.credit_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", bus.credit_overflow); end
    tick();
    tick();
    total++; if (bus.credit_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b want=1", bus.credit_overflow); end
  endtask

  task automatic test_reset_mid_hold();
    setReq(2, 64'hBEEF, 32'h9);
    setReq(1, 64'h2121, 32'h8);
    setReq(3, 64'h3131, 32'h7);
    bus.req_valid = 4'b0100;
    #1;
    total++; if (bus.req_yumi !== 4'b0100) begin bad++; $display("[TB] FAIL mid_grant got=%b want=0100", bus.req_yumi); end
    tick();
    bus.req_valid = 4'b1010;
    total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2) begin
      bad++; $display("[TB] FAIL mid_hold got=%b/%0d want=1/2", bus.out_valid, bus.out_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.credit_count !== 8'd4) begin bad++; $display("[TB] FAIL mid_credit got=%0d want=4", bus.credit_count); end
    total++; if (bus.credit_overflow !== 1'b0) begin bad++; $display("[TB] FAIL mid_ovf got=%b want=0", bus.credit_overflow); end
    total++; if (bus.req_yumi !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rst_yumi got=%b want=0000", bus.req_yumi); end
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (bus.req_yumi !== 4'b0010) begin bad++; $display("[TB] FAIL mid_after got=%b want=0010", bus.req_yumi); end
    tick();
    total++; if (bus.out_src !== 2'd1 || bus.out_data !== 64'h2121) begin
      bad++; $display("[TB] FAIL mid_src got=%0d/%h want=1/2121", bus.out_src, bus.out_data);
    end
    bus.req_valid = '0;
    bus.out_yumi  = 1'b1;
    tick();
    bus.out_yumi  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_send();
    test_round_robin();
    test_credit_exhaustion();
    test_backpressure();
    test_credit_overflow();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
